rr_priority_arbiter: RTL and testbench
======================================

// Module: rr_priority_arbiter
// PURPOSE
//  Parametrised N-way request arbiter; successor to the 3-bit combinational priority encoder.
//  Selectable mode: fixed priority (highest index wins) or round-robin (rotating priority).
//  Registered grant with valid/ready handshake; the grant holds until the consumer accepts it.
//  Sits between N requesting agents and one shared resource (bus or memory port).
// PARAMETERS
//  N_REQ   8                    number of requesters, >=2
//  RR_EN   1                    0 = fixed priority (index N_REQ-1 highest); 1 = round-robin
//  IDX_W   $clog2(N_REQ)        width of the encoded grant index (derived, not overridden)
// PORTS
//  clk        in   1      single clock, all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  req        in   N_REQ  request vector, level-sensitive, one bit per agent
//  gnt_ready  in   1      consumer accepts the current grant this cycle
//  gnt_valid  out  1      grant outputs are valid (registered)
//  gnt_onehot out  N_REQ  one-hot grant (registered), all zeros when gnt_valid=0
//  gnt_idx    out  IDX_W  encoded winner index (registered), 0 when gnt_valid=0
//  any_req    out  1      combinational |req; replaces the old "valid" output
// BEHAVIOUR
//  Reset (rst=1 at an edge): gnt_valid=0, gnt_onehot=0, gnt_idx=0, ptr=N_REQ-1, state=IDLE.
//    Reset wins over every other event, including a handshake in the same cycle. The grant in
//    flight is dropped.
//  FSM with 2 states:
//    IDLE : if |req at an edge, go to GRANT. The winner is computed from req in that cycle.
//           Latency from req to gnt_valid is 1 cycle.
//    GRANT: gnt_valid=1. gnt_onehot and gnt_idx are held stable until gnt_valid&gnt_ready at an
//           edge. The grant is sticky: if the winner deasserts its req, the grant stays.
//    On a handshake edge:
//      - |req=1: re-arbitrate with the updated ptr and stay in GRANT. This gives back-to-back
//        grants, one per cycle.
//      - |req=0: return to IDLE and clear the outputs.
//  Winner search:
//    - Fixed mode: the highest set index of req wins. ptr is unused and held at N_REQ-1.
//    - RR mode: search downward from ptr with wrap (ptr, ptr-1, .., 0, N_REQ-1, ..).
//      The first set bit wins.
//  Pointer update (RR mode only, on handshake only): ptr <= (winner==0) ? N_REQ-1 : winner-1.
//    The accepted agent becomes lowest priority. ptr never moves without a handshake.
//  Because reset gives ptr=N_REQ-1, the first RR arbitration equals fixed priority.
//  With a single requester continuously asserted in RR mode, that agent is granted every cycle.
//  gnt_ready while gnt_valid=0 is ignored.
//  Invariant: gnt_valid=1 implies $onehot(gnt_onehot) and gnt_onehot[gnt_idx]=1.
//  Width rules: IDX_W index arithmetic wraps explicitly at N_REQ-1, so non-power-of-2 N_REQ
//    is legal. Indices >= N_REQ are never produced.
// STRUCTURE
//  arb_pkg:
//    - typedef enum logic {IDLE, GRANT} arb_state_e
//    - function onehot_to_idx()
//  Sub-module rotating_prio_enc: combinational.
//    - Inputs: req and ptr. Outputs: onehot, idx, found.
//    - Implementation: double-width masked search, so no loops over the state.
//    - With ptr tied to N_REQ-1 it doubles as the fixed-priority encoder.
//  Top level: FSM, ptr register, output registers, any_req assign.
// TESTING
//  1. Hold rst=1 for 2 cycles with req=8'hFF -> gnt_valid=0, gnt_onehot=0, gnt_idx=0 throughout.
//  2. RR_EN=0, req=8'b0010_0110, gnt_ready=1 held -> gnt_idx=5 every cycle from cycle 1 on.
//  3. RR_EN=1, req=8'b1000_0101, gnt_ready=1 held -> gnt_idx sequence 7,2,0,7,2,0...
//     gnt_valid stays 1 throughout.
//  4. RR_EN=1, req=8'b0000_1000 then req=0 one cycle later, gnt_ready=0 for 3 cycles ->
//     gnt_idx=3 and gnt_onehot=8'h08 held stable.
//     Then gnt_ready=1 -> gnt_valid=0 on the next edge.
//  5. RR_EN=1, N_REQ=5, req=5'b00001 then 5'b10001 after accept ->
//     grants 0 then 4, with ptr wrapping from 0 to 4.
//  6. Assert rst during a GRANT with gnt_ready=1 -> outputs zero on the next edge, ptr=N_REQ-1.
//     The first post-reset grant follows fixed-priority order.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
//   arb_state_e   : two-state arbiter FSM encoding (IDLE, GRANT)
//   MAX_REQ       : widest request vector the index helper can encode
//   onehot_to_idx : binary index of a one-hot vector (0 for an all-zero vector)
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 64;

  // OR of the indices of all set bits: exact for a one-hot input, a plain
  // OR tree in hardware with no priority chain.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rotating_prio_enc.sv
// Combinational rotating priority encoder.
// Finds the first set bit of req searching downward from ptr with wrap-around
// (ptr, ptr-1, .., 0, N_REQ-1, .., ptr+1). With ptr tied to N_REQ-1 it is a
// plain highest-index-wins priority encoder.
//   req    in  N_REQ  request vector
//   ptr    in  IDX_W  highest-priority index for this search (< N_REQ)
//   onehot out N_REQ  one-hot winner, zero when nothing is requested
//   idx    out IDX_W  binary winner index, zero when nothing is requested
//   found  out 1      at least one request is set
module rotating_prio_enc
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 8,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int unsigned DW = 2 * N_REQ;

  logic [DW-1:0]  dbl;
  logic [DW-1:0]  mask;
  logic [DW-1:0]  masked;
  logic [DW-1:0]  rev;
  logic [DW-1:0]  rev_low;
  logic [DW-1:0]  hit;
  logic [IDX_W:0] shamt;

  // In {req, req} the downward wrapped search order starting at ptr is simply
  // descending bit order starting at ptr+N_REQ. Masking off everything above
  // ptr+N_REQ turns the rotating search into "highest set bit".
  assign dbl    = {req, req};
  assign shamt  = (IDX_W+1)'(N_REQ - 1) - {1'b0, ptr};
  assign mask   = {DW{1'b1}} >> shamt;
  assign masked = dbl & mask;

  // Highest set bit via bit reversal and the x & -x lowest-bit isolate.
  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      rev[i] = masked[DW-1-i];
    end
  end

  assign rev_low = rev & (~rev + DW'(1));

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      hit[i] = rev_low[DW-1-i];
    end
  end

  // Only one bit of hit is set, in either half; fold both halves together.
  assign onehot = hit[DW-1:N_REQ] | hit[N_REQ-1:0];
  assign idx    = IDX_W'(onehot_to_idx(MAX_REQ'(onehot)));
  assign found  = |req;

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way request arbiter with a registered, valid/ready-handshaked grant.
// RR_EN=0 : fixed priority, index N_REQ-1 highest.
// RR_EN=1 : round-robin; an accepted agent becomes lowest priority.
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   req        in  N_REQ  level-sensitive requests
//   gnt_ready  in  1      consumer accepts the presented grant
//   gnt_valid  out 1      grant is valid (registered)
//   gnt_onehot out N_REQ  one-hot grant, zero when not valid (registered)
//   gnt_idx    out IDX_W  winner index, zero when not valid (registered)
//   any_req    out 1      combinational OR of req
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 8,
  parameter  bit          RR_EN = 1'b1,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] enc_ptr;
  logic [N_REQ-1:0] gnt_onehot_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [N_REQ-1:0] enc_onehot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             handshake;

  assign handshake = (state_q == GRANT) && gnt_ready;

  // The pointer only moves on an accepted grant, and the re-arbitration in
  // that same cycle already searches from the moved pointer, so the encoder
  // is fed the next-state pointer rather than the registered one.
  always_comb begin
    ptr_nxt = ptr_q;
    if (RR_EN && handshake) begin
      ptr_nxt = (gnt_idx_q == '0) ? LAST_IDX : gnt_idx_q - IDX_W'(1);
    end
  end

  assign enc_ptr = RR_EN ? ptr_nxt : LAST_IDX;

  rotating_prio_enc #(
    .N_REQ (N_REQ)
  ) u_enc (
    .req    (req),
    .ptr    (enc_ptr),
    .onehot (enc_onehot),
    .idx    (enc_idx),
    .found  (enc_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= LAST_IDX;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
    end else begin
      ptr_q <= ptr_nxt;
      case (state_q)
        IDLE: begin
          if (enc_found) begin
            state_q      <= GRANT;
            gnt_onehot_q <= enc_onehot;
            gnt_idx_q    <= enc_idx;
          end
        end
        GRANT: begin
          // Sticky grant: held until accepted, regardless of req.
          if (gnt_ready) begin
            if (enc_found) begin
              gnt_onehot_q <= enc_onehot;
              gnt_idx_q    <= enc_idx;
            end else begin
              state_q      <= IDLE;
              gnt_onehot_q <= '0;
              gnt_idx_q    <= '0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          gnt_onehot_q <= '0;
          gnt_idx_q    <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_onehot = gnt_onehot_q;
  assign gnt_idx    = gnt_idx_q;
  assign any_req    = |req;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;

  localparam int NI = 3;
  localparam int QD = 4096;

  function automatic int nr_of(input int g);
    return (g == 2) ? 5 : 8;
  endfunction

  function automatic bit rr_of(input int g);
    return (g != 0);
  endfunction

  function automatic logic [7:0] lowmask(input int n);
    return 8'((1 << n) - 1);
  endfunction

  // Reference winner: walk candidate indices p, p-1, ... modulo n.
  function automatic int pick(input logic [7:0] r, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p - k + n) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       armed = 1'b0;
  logic [7:0] req_s   [NI];
  logic       rdy_s   [NI];
  logic [7:0] oh_s    [NI];
  logic [2:0] idx_s   [NI];
  logic       valid_s [NI];
  logic       any_s   [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : u
      localparam int unsigned NR = nr_of(g);
      localparam bit          RR = rr_of(g);
      localparam int unsigned IW = $clog2(NR);
      logic [NR-1:0] req_g;
      logic [NR-1:0] oh_g;
      logic [IW-1:0] idx_g;
      logic          valid_g;
      logic          any_g;
      assign req_g      = req_s[g][NR-1:0];
      assign oh_s[g]    = 8'(oh_g);
      assign idx_s[g]   = 3'(idx_g);
      assign valid_s[g] = valid_g;
      assign any_s[g]   = any_g;
      rr_priority_arbiter #(
        .N_REQ (NR),
        .RR_EN (RR)
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req_g),
        .gnt_ready  (rdy_s[g]),
        .gnt_valid  (valid_g),
        .gnt_onehot (oh_g),
        .gnt_idx    (idx_g),
        .any_req    (any_g)
      );
    end
  endgenerate

  // Reference model: at each edge decide which grants get issued.
  bit         busy [NI];
  int         mptr [NI];
  int         cur  [NI];
  int         wr   [NI];
  int         rd   [NI];
  int         expq [NI][QD];
  int         m_n;
  logic [7:0] m_r;

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      m_n = nr_of(g);
      m_r = req_s[g] & lowmask(m_n);
      if (rst) begin
        busy[g] = 1'b0;
        mptr[g] = m_n - 1;
      end else if (!busy[g]) begin
        if (m_r != 0) begin
          cur[g] = pick(m_r, m_n, rr_of(g) ? mptr[g] : m_n - 1);
          expq[g][wr[g] % QD] = cur[g];
          wr[g]++;
          busy[g] = 1'b1;
        end
      end else if (rdy_s[g]) begin
        if (rr_of(g)) mptr[g] = (cur[g] + m_n - 1) % m_n;
        if (m_r != 0) begin
          cur[g] = pick(m_r, m_n, rr_of(g) ? mptr[g] : m_n - 1);
          expq[g][wr[g] % QD] = cur[g];
          wr[g]++;
        end else begin
          busy[g] = 1'b0;
        end
      end
    end
  end

  // Directed expectations for the current cycle, set by the stimulus process.
  bit dir_en    [NI];
  bit dir_valid [NI];
  int dir_idx   [NI];
  int dir_oh    [NI];

  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, g, act, exp, $time);
  endtask

  // Monitor: compares presented grants against the queued expectations.
  int         pend;
  int         e;
  logic [7:0] mr;

  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < NI; g++) begin
        mr = req_s[g] & lowmask(nr_of(g));
        chk("any_req", g, int'(any_s[g]), int'(|mr));
        pend = wr[g] - rd[g];
        if (valid_s[g]) begin
          chk("grant_expected", g, int'(pend > 0), 1);
          if (pend > 0) begin
            e = expq[g][rd[g] % QD];
            chk("gnt_idx", g, int'(idx_s[g]), e);
            chk("gnt_onehot", g, int'(oh_s[g]), 1 << e);
            if (rdy_s[g]) rd[g]++;
          end
        end else begin
          chk("idle_pending", g, pend, 0);
          chk("idle_idx", g, int'(idx_s[g]), 0);
          chk("idle_onehot", g, int'(oh_s[g]), 0);
        end
        if (dir_en[g]) begin
          chk("dir_valid", g, int'(valid_s[g]), int'(dir_valid[g]));
          if (dir_valid[g]) begin
            chk("dir_idx", g, int'(idx_s[g]), dir_idx[g]);
            chk("dir_onehot", g, int'(oh_s[g]), dir_oh[g]);
          end
        end
        if (rst) rd[g] = wr[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) dir_en[g] = 1'b0;
  endtask

  task automatic setall(input logic [7:0] r, input logic rd_in);
    for (int g = 0; g < NI; g++) begin
      req_s[g] = r;
      rdy_s[g] = rd_in;
    end
  endtask

  task automatic expect_g(input int g, input bit v, input int ix, input int oh);
    dir_en[g]    = 1'b1;
    dir_valid[g] = v;
    dir_idx[g]   = ix;
    dir_oh[g]    = oh;
  endtask

  task automatic expect_idle_all();
    for (int g = 0; g < NI; g++) expect_g(g, 1'b0, 0, 0);
  endtask

  int seq3 [6] = '{7, 2, 0, 7, 2, 0};

  initial begin
    rst = 1'b1;
    setall(8'hFF, 1'b1);
    for (int g = 0; g < NI; g++) begin
      wr[g] = 0;
      rd[g] = 0;
      dir_en[g] = 1'b0;
    end

    // Reset held for two edges with every request raised.
    tick(); armed = 1'b1; expect_idle_all();
    tick(); expect_idle_all(); rst = 1'b0; setall(8'h00, 1'b0);
    tick(); setall(8'b0010_0110, 1'b1);

    // Fixed priority: index 5 wins every cycle.
    repeat (6) begin
      tick(); expect_g(0, 1'b1, 5, 8'h20);
    end

    // Reset during a grant with gnt_ready high drops the grant.
    tick(); rst = 1'b1;
    tick(); expect_idle_all(); rst = 1'b0; setall(8'b1000_0101, 1'b1);

    // Round-robin rotation 7,2,0,...; first post-reset grant is fixed order.
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_g(1, 1'b1, seq3[i], 1 << seq3[i]);
      if (i == 0) expect_g(2, 1'b1, 2, 8'h04);
    end

    // Sticky grant held while not accepted, then released to idle.
    tick(); rst = 1'b1; setall(8'h00, 1'b0);
    tick(); rst = 1'b0; setall(8'h08, 1'b0);
    tick(); expect_g(1, 1'b1, 3, 8'h08); setall(8'h00, 1'b0);
    tick(); expect_g(1, 1'b1, 3, 8'h08);
    tick(); expect_g(1, 1'b1, 3, 8'h08); setall(8'h00, 1'b1);
    tick(); expect_g(1, 1'b0, 0, 0); setall(8'h00, 1'b0);

    // N_REQ=5: grant 0, then pointer wraps to 4.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; setall(8'h01, 1'b0); expect_idle_all();
    tick(); expect_g(2, 1'b1, 0, 8'h01); setall(8'h11, 1'b1);
    tick(); expect_g(2, 1'b1, 4, 8'h10); setall(8'h00, 1'b0);

    // Randomized traffic against the reference model.
    repeat (3000) begin
      tick();
      rst = ($urandom_range(63) == 0);
      for (int g = 0; g < NI; g++) begin
        if ($urandom_range(3) == 0) req_s[g] = 8'($urandom);
        else req_s[g] = 8'($urandom & $urandom & $urandom);
        rdy_s[g] = ($urandom_range(2) != 0);
      end
    end

    tick(); rst = 1'b1; setall(8'h00, 1'b0);
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
